// File: rtl/adder_pkg.sv
// Shared definitions for the round-robin adder slice: operand/result widths
// and the result-register state encoding.
package adder_pkg;

  localparam int A_W   = 63;
  localparam int B_W   = 6;
  localparam int SUM_W = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/customAdder63_57.sv
// Combinational unsigned adder: 63-bit A plus zero-extended 6-bit B,
// producing a 64-bit sum whose top bit is the carry out.
module customAdder63_57
  import adder_pkg::*;
(
  input  logic [A_W-1:0]   i_a,
  input  logic [B_W-1:0]   i_b,
  output logic [SUM_W-1:0] o_sum
);

  logic [SUM_W-1:0] w_aExt;
  logic [SUM_W-1:0] w_bExt;

  assign w_aExt = {{(SUM_W-A_W){1'b0}}, i_a};
  assign w_bExt = {{(SUM_W-B_W){1'b0}}, i_b};
  assign o_sum  = w_aExt + w_bExt;

endmodule

// File: rtl/adder63_rr_arbiter.sv
// Round-robin arbiter sharing one 63+6-bit adder among NUM_REQ requesters,
// with a single registered result slot drained through a valid/ready port.
module adder63_rr_arbiter
  import adder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SUM_W-1:0]       rsp_sum,
  output logic [IDW-1:0]         rsp_id,
  output logic [15:0]            busy_cnt
);

  state_t             r_state;
  state_t             w_nextState;
  logic [IDW-1:0]     r_lastGrant;
  logic [SUM_W-1:0]   r_sum;
  logic [IDW-1:0]     r_id;
  logic [15:0]        r_busyCnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_grantIdx;
  logic               w_found;
  logic               w_slotFree;
  logic               w_accept;
  logic [A_W-1:0]     w_opA;
  logic [B_W-1:0]     w_opB;
  logic [SUM_W-1:0]   w_sum;

  // Search starts one past the last winner and wraps, so every requester is
  // reached within NUM_REQ grants.
  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    w_found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_lastGrant) + k) % NUM_REQ]) begin
        w_found    = 1'b1;
        w_grantIdx = IDW'((int'(r_lastGrant) + k) % NUM_REQ);
        w_grant[(int'(r_lastGrant) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  assign w_slotFree = !rst && ((r_state == ST_EMPTY) || rsp_ready);
  assign req_ready  = w_slotFree ? w_grant : '0;
  assign w_accept   = |req_ready;

  assign w_opA = req_a[int'(w_grantIdx)*A_W +: A_W];
  assign w_opB = req_b[int'(w_grantIdx)*B_W +: B_W];

  customAdder63_57 u_adder (
    .i_a   (w_opA),
    .i_b   (w_opB),
    .o_sum (w_sum)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_nextState = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_accept) w_nextState = ST_EMPTY;
      default:  w_nextState = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_lastGrant <= IDW'(NUM_REQ - 1);
      r_sum       <= '0;
      r_id        <= '0;
      r_busyCnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_lastGrant <= w_grantIdx;
        r_sum       <= w_sum;
        r_id        <= w_grantIdx;
      end
      if ((r_state == ST_FULL) && !rsp_ready && (r_busyCnt != 16'hFFFF)) begin
        r_busyCnt <= r_busyCnt + 16'd1;
      end
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
  assign busy_cnt  = r_busyCnt;

endmodule

// File: tb/tb_adder63_rr_arbiter.sv
// Randomized bench for adder63_rr_arbiter: a behavioural model tracks the
// result slot and round-robin pointer; directed cases pin known values.
module tb_adder63_rr_arbiter;

  localparam int NUM = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM-1:0]     reqValid = '0;
  logic [NUM*63-1:0]  reqA;
  logic [NUM*6-1:0]   reqB;
  logic [NUM-1:0]     reqReady;
  logic               rspValid;
  logic               rspReady = 1'b0;
  logic [63:0]        rspSum;
  logic [1:0]         rspId;
  logic [15:0]        busyCnt;

  logic [62:0]        opA [NUM];
  logic [5:0]         opB [NUM];

  int total = 0;
  int bad   = 0;
  logic checkEnable = 1'b0;

  // Behavioural model of the result slot
  logic        mValid = 1'b0;
  logic [63:0] mSum   = '0;
  int          mId    = 0;
  int          mLast  = NUM - 1;
  int          mBusy  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      reqA[i*63 +: 63] = opA[i];
      reqB[i*6 +: 6]   = opB[i];
    end
  end

  adder63_rr_arbiter #(.NUM_REQ(NUM), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_ready (reqReady),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_sum   (rspSum),
    .rsp_id    (rspId),
    .busy_cnt  (busyCnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM-1:0] valid, input logic ready);
    @(negedge clk);
    rst      = 1'b0;
    reqValid = valid;
    rspReady = ready;
  endtask

  // Winner index the model expects this cycle, or -1 if nothing is accepted
  function automatic int modelWinner();
    if (rst || (mValid && !rspReady)) return -1;
    for (int k = 1; k <= NUM; k++) begin
      if (reqValid[(mLast + k) % NUM]) return (mLast + k) % NUM;
    end
    return -1;
  endfunction

  function automatic logic [NUM-1:0] modelReady();
    logic [NUM-1:0] g;
    int w;
    g = '0;
    w = modelWinner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  always @(posedge rst) begin
    mValid = 1'b0;
    mSum   = '0;
    mId    = 0;
    mLast  = NUM - 1;
    mBusy  = 0;
  end

  always @(posedge clk) begin
    int w;
    if (!rst) begin
      w = modelWinner();
      if (mValid && !rspReady && mBusy < 65535) mBusy = mBusy + 1;
      if (w >= 0) begin
        mSum   = {1'b0, opA[w]} + 64'(opB[w]);
        mId    = w;
        mLast  = w;
        mValid = 1'b1;
      end else if (rspReady) begin
        mValid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (checkEnable) begin
      checkOutput("req_ready", 64'(reqReady), 64'(modelReady()));
      checkOutput("rsp_valid", 64'(rspValid), 64'(mValid));
      checkOutput("busy_cnt", 64'(busyCnt), 64'(mBusy));
      if (mValid) begin
        checkOutput("rsp_sum", rspSum, mSum);
        checkOutput("rsp_id", 64'(rspId), 64'(mId));
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("reset_valid", 64'(rspValid), 64'd0);
    checkOutput("reset_sum", rspSum, 64'd0);
    checkOutput("reset_id", 64'(rspId), 64'd0);
    checkOutput("reset_busy", 64'(busyCnt), 64'd0);
    checkOutput("reset_ready", 64'(reqReady), 64'd0);
    checkEnable = 1'b1;

    // Single request
    applyStimulus(4'b0001, 1'b1);
    opA[0] = 63'd5; opB[0] = 6'd3;
    #3 checkOutput("single_ready", 64'(reqReady), 64'h1);
    applyStimulus(4'b0000, 1'b0);
    #3;
    checkOutput("single_valid", 64'(rspValid), 64'd1);
    checkOutput("single_sum", rspSum, 64'd8);
    checkOutput("single_id", 64'(rspId), 64'd0);

    // Carry out of the top bit
    applyStimulus(4'b0010, 1'b1);
    opA[1] = 63'h7FFF_FFFF_FFFF_FFFF; opB[1] = 6'd63;
    #3 checkOutput("carry_ready", 64'(reqReady), 64'h2);
    applyStimulus(4'b0000, 1'b0);
    #3;
    checkOutput("carry_sum", rspSum, 64'h8000_0000_0000_003E);
    checkOutput("carry_id", 64'(rspId), 64'd1);

    // Fairness from a fresh reset: grants rotate 0,1,2,3,0,...
    @(negedge clk); rst = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < NUM; i++) begin
      opA[i] = 63'(100 * (i + 1)); opB[i] = 6'(i + 1);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) applyStimulus(4'b1111, 1'b1);
      #3;
      checkOutput("fair_grant", 64'(reqReady), 64'(1 << (k % 4)));
      if (k > 0) begin
        checkOutput("fair_valid", 64'(rspValid), 64'd1);
        checkOutput("fair_id", 64'(rspId), 64'((k - 1) % 4));
      end
    end

    // Backpressure: result 10+1 held for five stalled cycles
    applyStimulus(4'b0001, 1'b1);
    opA[0] = 63'd10; opB[0] = 6'd1;
    #3 checkOutput("bp_load_ready", 64'(reqReady), 64'h1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b0);
      #3;
      checkOutput("bp_ready_low", 64'(reqReady), 64'h0);
      checkOutput("bp_sum_hold", rspSum, 64'd11);
    end
    applyStimulus(4'b1111, 1'b1);
    #3;
    checkOutput("bp_busy", 64'(busyCnt), 64'd5);
    checkOutput("bp_refill_ready", 64'(reqReady), 64'h2);
    applyStimulus(4'b0000, 1'b0);
    #3;
    checkOutput("bp_refill_sum", rspSum, 64'd202);
    checkOutput("bp_refill_id", 64'(rspId), 64'd1);

    // Reset while a result is held
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 64'(rspValid), 64'd0);
    checkOutput("rst_mid_busy", 64'(busyCnt), 64'd0);
    checkOutput("rst_mid_ready", 64'(reqReady), 64'h0);
    applyStimulus(4'b1111, 1'b1);
    #3 checkOutput("rst_mid_grant", 64'(reqReady), 64'h1);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 600; n++) begin
      applyStimulus(4'($urandom), $urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM; i++) begin
        opA[i] = 63'({$urandom(), $urandom()});
        opB[i] = 6'($urandom);
        if ($urandom_range(0, 7) == 0) opA[i] = '1;
        if ($urandom_range(0, 7) == 0) opB[i] = '1;
      end
      if ($urandom_range(0, 59) == 0) begin
        #4 rst = 1'b1;
      end
    end

    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
